// File: rtl/sub32b_seq_if.sv
// sub32b_seq_if: handshake bundle for the sequential subtractor.
//   in_valid/in_ready/a/b     operand request (master -> slave)
//   out_valid/out_ready       result handshake
//   diff/borrow/zero          result fields (slave -> master)
// master = the requester (PE control / bench), slave = sub32b_seq.
interface sub32b_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero
  );
endinterface

// File: rtl/sub32b_seq.sv
// sub32b_seq: multi-cycle unsigned subtractor, diff = a - b, one 4-bit
// nibble per clock through a single ripple-borrow slice. One operation in
// flight; valid/ready on both sides.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    sub32b_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready,
//          diff/borrow/zero)
//
// Optional build macro: SUB_SATURATE_EN -- when defined, a negative result
// (final borrow = 1) is clamped to diff = 0 (borrow still 1, zero = 1).
//
// Timing: accept at edge E0, nibble k-1 computed at edge Ek (k = 1..NIB),
// out_valid from E_NIB until the output handshake edge. WIDTH must be a
// multiple of 4 and >= 4.

// One nibble of ripple-borrow subtraction: {bout, d} = a - b - bin.
// The 5-bit difference goes negative exactly when a borrow is needed, which
// shows up as bit 4 set.
module sub4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [4:0] r;

  assign r    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
  assign d    = r[3:0];
  assign bout = r[4];
endmodule

module sub32b_seq #(
  parameter  int WIDTH = 32,
  localparam int NIB   = WIDTH / 4
) (
  input  logic          clk,
  input  logic          reset,
  sub32b_seq_if.slave   bus
);
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] diff_r, diff_wr, diff_fin;
  logic [CW-1:0]    cnt;
  logic             bin_r;
  logic             borrow_r, zero_r;
  logic             last;
  logic [CW+1:0]    nib_lsb;
  logic [3:0]       a_nib, b_nib, d_nib;
  logic             bout;

  // bit offset of the nibble being worked on this cycle
  assign nib_lsb = {cnt, 2'b00};
  assign last    = (cnt == CW'(NIB - 1));
  assign a_nib   = opa[nib_lsb +: 4];
  assign b_nib   = opb[nib_lsb +: 4];

  sub4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (bin_r),
    .d    (d_nib),
    .bout (bout)
  );

  // diff with the current nibble merged in; on the last step this is the
  // full result, so saturation and the zero flag key off it directly.
  always_comb begin
    diff_wr = diff_r;
    diff_wr[nib_lsb +: 4] = d_nib;
  end

`ifdef SUB_SATURATE_EN
  assign diff_fin = bout ? '0 : diff_wr;
`else
  assign diff_fin = diff_wr;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.diff      = diff_r;
    bus.borrow    = borrow_r;
    bus.zero      = zero_r;
  end

  // ---------------- datapath ----------------
  // borrow/zero only move on the final step so they hold through DONE and
  // IDLE; diff is scratch during RUN and only meaningful in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa      <= '0;
      opb      <= '0;
      diff_r   <= '0;
      cnt      <= '0;
      bin_r    <= 1'b0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            opa   <= bus.a;
            opb   <= bus.b;
            bin_r <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          bin_r <= bout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            diff_r   <= diff_fin;
            borrow_r <= bout;
            zero_r   <= (diff_fin == '0);
          end else begin
            diff_r   <= diff_wr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sub32b_seq.md
Name: sub32b_seq

Overview:
- Multi-cycle unsigned subtractor: computes diff = a - b on WIDTH-bit operands, 4 bits per clock, from a nibble-wide ripple-borrow slice.
- Inverse datapath to the adder cells; used where the PE array needs difference and comparison results (accumulator drain, max/compare).
- Valid/ready handshake on input and output; one operation in flight.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps per operation (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  operands on a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend (unsigned)
- b  input  WIDTH  subtrahend (unsigned)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH (saturated when SUB_SATURATE_EN is defined)
- borrow  output  1  1 when a < b
- zero  output  1  1 when diff == 0

Behaviour:
- Reset (reset low, asynchronous): state IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, zero=0, nibble counter=0, internal borrow=0.
- Reset asserted mid-operation aborts the operation. The result is discarded and the block returns to IDLE with the reset values above.
- State IDLE: in_ready=1. On in_valid && in_ready at edge E0:
  - latch a and b into operand registers;
  - clear the internal borrow to 0 (a plus ones-complement of b plus 1 is equivalent);
  - clear the counter;
  - go to RUN.
- State RUN: in_ready=0.
  - At each edge Ek (k=1..NIB), nibble k-1 is computed: d = a_nib - b_nib - borrow_in.
  - The result nibble is written into diff[4(k-1)+3 : 4(k-1)] and the borrow-out is registered.
  - After edge E_NIB, go to DONE.
  - in_valid is ignored in RUN.
- State DONE: out_valid=1.
  - diff, borrow and zero stay stable until the handshake completes.
  - borrow = final borrow-out.
  - zero = (diff == 0), computed on the final (post-saturation) diff.
  - On out_valid && out_ready: go to IDLE at that edge and drop out_valid.
  - diff, borrow and zero hold their last values in IDLE until the next result overwrites them.
- Latency: out_valid rises NIB cycles after the accept edge (8 cycles at WIDTH=32). The earliest next accept is the cycle after the output handshake.
- Throughput: one result per NIB+2 cycles when out_ready is held high.
- Back-pressure: out_ready low holds DONE indefinitely. No input is accepted meanwhile.
- Boundaries:
  - a == b gives diff=0, borrow=0, zero=1.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow=1.
  - Borrow ripples correctly across all nibble boundaries.
- diff is only guaranteed meaningful while out_valid=1.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when the final borrow=1, diff is forced to 0 in DONE; borrow still reports 1, and zero=1.
- Not defined: diff is the wrap-around two's-complement result modulo 2^WIDTH.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset low in mid-RUN (cycle 3 after accept of a=0x12345678, b=0x1) -> immediately out_valid=0, in_ready=1, diff=0; no result ever appears.
- a=0x12345678, b=0x00000001, out_ready=1 -> out_valid exactly 8 cycles after accept; diff=0x12345677, borrow=0, zero=0; in_ready=1 the cycle after the handshake.
- a=0x00000000, b=0xFFFFFFFF -> diff=0x00000001, borrow=1 (without SUB_SATURATE_EN); with SUB_SATURATE_EN: diff=0, borrow=1, zero=1.
- a=0x10000000, b=0x0FFFFFFF -> borrow ripple through all 8 nibbles; diff=0x00000001, borrow=0.
- a=b=0xDEADBEEF, with out_ready held low for 5 cycles after out_valid -> diff=0, zero=1, outputs stable all 5 cycles; in_valid pulses during the stall are not accepted (in_ready=0).
- Back-to-back: issue 0x5-0x3 then 0x3-0x5 with in_valid held high and out_ready=1 -> results 0x00000002 (borrow 0), then 0xFFFFFFFE (borrow 1); second accept occurs the cycle after the first output handshake.
